step_capture: RTL and testbench

STEP_CAPTURE -- requirements
Module: step_capture

---
 rtl/step_capture_if.sv | 37 +++
 rtl/step_capture.sv | 208 ++++++++++++++++++++
 tb/tb_step_capture.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_capture_if.sv
// ---------------------------------------------------------------------------
// step_capture_if
// Read-side bundle of the step_capture event FIFO.
//   rd_en    : pop the FIFO head (ignored while empty)
//   dout     : FIFO head {dir, timestamp[31:0]}, show-ahead, valid while !empty
//   empty    : FIFO holds no entries
//   full     : FIFO holds 2**FIFO_ADDR_BITS entries
//   elemcnt  : number of entries held
// Modports:
//   slave  - the capture block (drives data and status, receives rd_en)
//   master - the consumer (drives rd_en, receives data and status)
// ---------------------------------------------------------------------------
interface step_capture_if #(
    parameter int FIFO_ADDR_BITS = 4
);
    logic                      rd_en;
    logic [32:0]               dout;
    logic                      empty;
    logic                      full;
    logic [FIFO_ADDR_BITS:0]   elemcnt;

    modport slave (
        input  rd_en,
        output dout,
        output empty,
        output full,
        output elemcnt
    );

    modport master (
        output rd_en,
        input  dout,
        input  empty,
        input  full,
        input  elemcnt
    );
endinterface

// File: rtl/step_capture.sv
// ---------------------------------------------------------------------------
// step_capture
// Captures step/dir pulse trains from an external motion controller.
// Both lines are synchronised and glitch-filtered; every accepted step edge
// updates a signed 32-bit position and is time-stamped into a show-ahead FIFO.
//
// Ports:
//   clk           : system clock, all state on the rising edge
//   reset_n       : asynchronous active-low reset
//   step_in       : external step line (asynchronous to clk)
//   dir_in        : external direction line (asynchronous to clk)
//   dedge         : 0 = count rising step edges, 1 = count both edges
//   clock         : free-running system time, stored with each event
//   set_pos       : load position from pos_value (wins over a step event)
//   pos_value     : position load value
//   clear         : empty the FIFO and clear the sticky flags
//   position      : signed step position (wraps modulo 2**32)
//   overflow      : sticky, an event was dropped because the FIFO was full
//   dir_violation : sticky, an event arrived with dir stable < DIR_SETUP cycles
//   fifo          : FIFO read port (rd_en, dout, empty, full, elemcnt)
// ---------------------------------------------------------------------------
module step_capture #(
    parameter int FIFO_ADDR_BITS = 4,
    parameter int FILTER_CYCLES  = 2,
    parameter int DIR_SETUP      = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               step_in,
    input  logic               dir_in,
    input  logic               dedge,
    input  logic [31:0]        clock,
    input  logic               set_pos,
    input  logic [31:0]        pos_value,
    input  logic               clear,
    output logic [31:0]        position,
    output logic               overflow,
    output logic               dir_violation,
    step_capture_if.slave      fifo
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int AGE_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);

    localparam logic [3:0]                FILT_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic [AGE_W-1:0]          AGE_MAX   = AGE_W'(DIR_SETUP);
    localparam logic [FIFO_ADDR_BITS:0]   CNT_FULL  = (FIFO_ADDR_BITS + 1)'(DEPTH);

    // -----------------------------------------------------------------------
    // Input conditioning: index 0 = step, index 1 = dir.
    // filt_accept pulses in the cycle whose clock edge updates the filtered
    // level, so downstream logic can react on that same edge.
    // -----------------------------------------------------------------------
    logic [1:0] raw_level;
    logic [1:0] filt_level;
    logic [1:0] filt_accept;

    assign raw_level = {dir_in, step_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic       sync1_reg;
            logic       sync2_reg;
            logic       level_reg;
            logic [3:0] cnt_reg;

            // The synchronised level must disagree with the filtered level on
            // FILTER_CYCLES consecutive cycles; any agreement restarts the count.
            assign filt_accept[gi] = (sync2_reg != level_reg) && (cnt_reg == FILT_LAST);
            assign filt_level[gi]  = level_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= 4'd0;
                end else begin
                    sync1_reg <= raw_level[gi];
                    sync2_reg <= sync1_reg;
                    if (filt_accept[gi]) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= 4'd0;
                    end else if (sync2_reg != level_reg) begin
                        cnt_reg   <= cnt_reg + 4'd1;
                    end else begin
                        cnt_reg   <= 4'd0;
                    end
                end
            end
        end
    endgenerate

    logic step_f;
    logic dir_f;

    assign step_f = filt_level[0];
    assign dir_f  = filt_level[1];

    // -----------------------------------------------------------------------
    // Event detection and direction setup tracking
    // -----------------------------------------------------------------------
    logic              step_d_reg;
    logic [AGE_W-1:0]  dir_age_reg;
    logic              step_event;
    logic              setup_bad;

    // step_d_reg resets to the same level as step_f, so leaving reset never
    // produces an event by itself.
    assign step_event = dedge ? (step_f ^ step_d_reg) : (step_f & ~step_d_reg);

    // dir_f and dir_age_reg are read before the edge that might change them,
    // so a direction change landing on the event edge is not yet visible.
    assign setup_bad = step_event && (dir_age_reg < AGE_MAX);

    // -----------------------------------------------------------------------
    // Event FIFO
    // -----------------------------------------------------------------------
    logic [32:0]                 mem_reg [DEPTH];
    logic [FIFO_ADDR_BITS-1:0]   wr_ptr_reg;
    logic [FIFO_ADDR_BITS-1:0]   rd_ptr_reg;
    logic [FIFO_ADDR_BITS:0]     count_reg;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        pop;
    logic                        push;
    logic [FIFO_ADDR_BITS-1:0]   wr_addr;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_FULL);

    // A clear discards everything, so a same-cycle pop is meaningless and the
    // event (if any) becomes the sole entry at address 0.
    assign pop     = fifo.rd_en && !fifo_empty && !clear;
    assign push    = step_event && (clear || !fifo_full || pop);
    assign wr_addr = clear ? '0 : wr_ptr_reg;

    // Storage carries no reset: pointers define which words are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_addr] <= {dir_f, clock};
        end
    end

    logic [31:0] position_reg;
    logic        overflow_reg;
    logic        dir_violation_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_d_reg        <= 1'b0;
            dir_age_reg       <= AGE_MAX;
            position_reg      <= 32'd0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            overflow_reg      <= 1'b0;
            dir_violation_reg <= 1'b0;
        end else begin
            step_d_reg <= step_f;

            if (filt_accept[1]) begin
                dir_age_reg <= '0;
            end else if (dir_age_reg < AGE_MAX) begin
                dir_age_reg <= dir_age_reg + 1'b1;
            end

            if (set_pos) begin
                position_reg <= pos_value;
            end else if (step_event) begin
                position_reg <= dir_f ? (position_reg + 32'd1) : (position_reg - 32'd1);
            end

            if (clear) begin
                rd_ptr_reg        <= '0;
                wr_ptr_reg        <= push ? FIFO_ADDR_BITS'(1) : '0;
                count_reg         <= push ? (FIFO_ADDR_BITS + 1)'(1) : '0;
                overflow_reg      <= 1'b0;
                dir_violation_reg <= setup_bad;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg
                             + {{FIFO_ADDR_BITS{1'b0}}, push}
                             - {{FIFO_ADDR_BITS{1'b0}}, pop};
                if (step_event && !push) begin
                    overflow_reg <= 1'b1;
                end
                if (setup_bad) begin
                    dir_violation_reg <= 1'b1;
                end
            end
        end
    end

    assign fifo.dout      = mem_reg[rd_ptr_reg];
    assign fifo.empty     = fifo_empty;
    assign fifo.full      = fifo_full;
    assign fifo.elemcnt   = count_reg;
    assign position       = position_reg;
    assign overflow       = overflow_reg;
    assign dir_violation  = dir_violation_reg;

endmodule

// File: tb/tb_step_capture.sv
// ---------------------------------------------------------------------------
// tb_step_capture
// Directed scenarios followed by randomized step/dir traffic. A reference
// model predicts events from input-level changes: a clean level change first
// sampled at clock value k produces its event at clock value k+2+FILTER_CYCLES,
// using the latest dir change sampled at or before k.
// ---------------------------------------------------------------------------
module tb_step_capture;

    localparam int AB    = 4;
    localparam int F     = 2;
    localparam int DS    = 7;
    localparam int DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_in;
    logic        dir_in;
    logic        dedge;
    logic [31:0] clock;
    logic        set_pos;
    logic [31:0] pos_value;
    logic        clear;
    logic [31:0] position;
    logic        overflow;
    logic        dir_violation;

    step_capture_if #(.FIFO_ADDR_BITS(AB)) fif ();

    step_capture #(
        .FIFO_ADDR_BITS (AB),
        .FILTER_CYCLES  (F),
        .DIR_SETUP      (DS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .step_in        (step_in),
        .dir_in         (dir_in),
        .dedge          (dedge),
        .clock          (clock),
        .set_pos        (set_pos),
        .pos_value      (pos_value),
        .clear          (clear),
        .position       (position),
        .overflow       (overflow),
        .dir_violation  (dir_violation),
        .fifo           (fif)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    int            total = 0;
    int            bad   = 0;
    int unsigned   clock_v;
    logic [32:0]   mq[$];
    logic [31:0]   m_pos;
    bit            m_ovf;
    bit            m_viol;
    int unsigned   sched_clk[$];
    bit            sched_lvl[$];
    int unsigned   dchg_clk[$];
    bit            dchg_lvl[$];
    bit            rd_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sched_clk.delete();
        sched_lvl.delete();
        dchg_clk.delete();
        dchg_lvl.delete();
        m_pos  = 32'd0;
        m_ovf  = 1'b0;
        m_viol = 1'b0;
    endtask

    // Apply one clock edge to the model, using the inputs that edge sampled.
    task automatic model_edge();
        bit          ev;
        bit          lvl;
        bit          dirv;
        bit          viol_now;
        int unsigned ks;
        int unsigned age;
        ev       = 1'b0;
        dirv     = 1'b0;
        viol_now = 1'b0;
        if (sched_clk.size() > 0 && sched_clk[0] == clock_v) begin
            lvl = sched_lvl[0];
            void'(sched_clk.pop_front());
            void'(sched_lvl.pop_front());
            ev = dedge || lvl;
            ks = clock_v - 2 - F;
        end
        if (ev) begin
            age = DS;
            foreach (dchg_clk[i]) begin
                if (dchg_clk[i] <= ks) begin
                    dirv = dchg_lvl[i];
                    age  = ((ks - dchg_clk[i]) < DS) ? (ks - dchg_clk[i]) : DS;
                end
            end
            viol_now = (age < DS);
        end
        if (clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_viol = 1'b0;
            if (ev) begin
                mq.push_back({dirv, clock_v});
                if (viol_now) m_viol = 1'b1;
            end
        end else begin
            if (fif.rd_en && mq.size() > 0) begin
                $display("pop  dir=%0d ts=%0d", mq[0][32], mq[0][31:0]);
                void'(mq.pop_front());
            end
            if (ev) begin
                if (viol_now) m_viol = 1'b1;
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back({dirv, clock_v});
            end
        end
        if (set_pos) m_pos = pos_value;
        else if (ev) m_pos = dirv ? (m_pos + 32'd1) : (m_pos - 32'd1);
    endtask

    task automatic compare_all();
        chk("position", position, m_pos);
        chk("elemcnt", fif.elemcnt, mq.size());
        chk("empty", fif.empty, mq.size() == 0);
        chk("full", fif.full, mq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("dir_violation", dir_violation, m_viol);
        if (mq.size() > 0) chk("dout", fif.dout, mq[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset_n) model_edge();
        compare_all();
        clock_v = clock_v + 1;
        clock   = clock_v;
    endtask

    task automatic rtick();
        fif.rd_en = rd_mode ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
        set_pos   = ($urandom_range(0, 40) == 0);
        pos_value = $urandom;
        clear     = ($urandom_range(0, 150) == 0);
        tick();
        fif.rd_en = 1'b0;
        set_pos   = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic set_step(input bit v);
        step_in = v;
        sched_clk.push_back(clock_v + 2 + F);
        sched_lvl.push_back(v);
    endtask

    task automatic set_dir(input bit v);
        dir_in = v;
        dchg_clk.push_back(clock_v);
        dchg_lvl.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        if (step_in) begin
            sched_clk.push_back(clock_v + 2 + F);
            sched_lvl.push_back(1'b1);
        end
        if (dir_in) begin
            dchg_clk.push_back(clock_v);
            dchg_lvl.push_back(1'b1);
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int op;
        reset_n   = 1'b0;
        step_in   = 1'b0;
        dir_in    = 1'b0;
        dedge     = 1'b0;
        set_pos   = 1'b0;
        pos_value = 32'd0;
        clear     = 1'b0;
        fif.rd_en = 1'b0;
        rd_mode   = 1'b0;
        clock_v   = 0;
        clock     = 32'd0;

        do_reset();
        repeat (3) tick();
        chk("reset_position", position, 32'd0);
        chk("reset_empty", fif.empty, 1'b1);

        // Clean step after a long-settled dir: stamped with the write-edge time.
        clock_v = 80;
        clock   = 32'd80;
        set_dir(1'b1);
        repeat (20) tick();
        set_step(1'b1);
        repeat (4) tick();
        chk("lat_before", position, 32'd0);
        tick();
        chk("lat_position", position, 32'd1);
        chk("lat_dout", fif.dout, {1'b1, 32'd104});
        chk("lat_viol", dir_violation, 1'b0);
        $display("step done  pos=%0d dout=%0h", position, fif.dout);
        set_step(1'b0);
        repeat (6) tick();
        fif.rd_en = 1'b1;
        tick();
        tick();
        fif.rd_en = 1'b0;
        chk("pop_empty", fif.empty, 1'b1);

        // Single-cycle glitch must be swallowed by the filter.
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        repeat (8) tick();
        chk("glitch_position", position, 32'd1);
        chk("glitch_empty", fif.empty, 1'b1);

        // Dir changed only 3 cycles before the step.
        set_dir(1'b0);
        repeat (3) tick();
        set_step(1'b1);
        repeat (6) tick();
        chk("setup_viol", dir_violation, 1'b1);
        chk("setup_position", position, 32'd0);
        set_step(1'b0);
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_viol", dir_violation, 1'b0);

        // Both-edge counting downward across zero.
        set_pos   = 1'b1;
        pos_value = 32'd2;
        tick();
        set_pos   = 1'b0;
        dedge     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_step(~step_in);
            repeat (5) tick();
        end
        chk("dedge_position", position, 32'hFFFF_FFFE);
        chk("dedge_elemcnt", fif.elemcnt, 5'd4);
        dedge = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Fill beyond depth, then a push that coincides with a pop while full.
        set_pos   = 1'b1;
        pos_value = 32'd0;
        set_dir(1'b1);
        tick();
        set_pos   = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 17; i++) begin
            set_step(1'b1);
            repeat (4) tick();
            set_step(1'b0);
            repeat (4) tick();
        end
        chk("fill_elemcnt", fif.elemcnt, 5'd16);
        chk("fill_full", fif.full, 1'b1);
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_position", position, 32'd17);
        set_step(1'b1);
        repeat (4) tick();
        fif.rd_en = 1'b1;
        tick();
        fif.rd_en = 1'b0;
        chk("fullrw_elemcnt", fif.elemcnt, 5'd16);
        chk("fullrw_position", position, 32'd18);
        set_step(1'b0);
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("fillclr_empty", fif.empty, 1'b1);
        chk("fillclr_overflow", overflow, 1'b0);

        // set_pos wins over a coincident step, entry still written.
        set_step(1'b1);
        repeat (4) tick();
        set_pos   = 1'b1;
        pos_value = 32'h8000_0000;
        tick();
        set_pos   = 1'b0;
        chk("setpos_position", position, 32'h8000_0000);
        chk("setpos_elemcnt", fif.elemcnt, 5'd1);
        set_step(1'b0);
        repeat (6) tick();

        // Clear coincident with an event keeps only that event.
        set_step(1'b1);
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrev_elemcnt", fif.elemcnt, 5'd1);
        set_step(1'b0);
        repeat (6) tick();

        // Reset mid-pulse with step_in held high: one rising event afterwards.
        set_step(1'b1);
        repeat (2) tick();
        do_reset();
        chk("rst_empty", fif.empty, 1'b1);
        repeat (6) tick();
        chk("rst_position", position, 32'd1);
        chk("rst_elemcnt", fif.elemcnt, 5'd1);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 0) rd_mode = ~rd_mode;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: set_step(~step_in);
                4: begin
                    step_in = ~step_in;
                    rtick();
                    step_in = ~step_in;
                end
                5: set_dir(~dir_in);
                6: begin
                    set_step(~step_in);
                    set_dir(~dir_in);
                end
                7: begin
                    set_step(~step_in);
                    rtick();
                    set_dir(~dir_in);
                end
                8: dedge = $urandom_range(0, 1);
                default: if ($urandom_range(0, 9) == 0) do_reset();
            endcase
            repeat ($urandom_range(4, 7)) rtick();
        end
        repeat (10) rtick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
